// File: rtl/bnn_pkg.sv
// Shared types and helpers for binarised dense layers.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int POP_MAX_W = 64;

  // Returns at least 1 so single-entry tables still get a legal index width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int nchunk(input int n_in, input int chunk);
    return (n_in + chunk - 1) / chunk;
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX_W; i++) c += {31'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/bnn_layer_seq_if.sv
// Bus bundle for one sequential BNN layer: input/output streams, weight ROM, threshold port.
interface bnn_layer_seq_if import bnn_pkg::*; #(
  parameter int N_IN  = 50,
  parameter int N_OUT = 10,
  parameter int CHUNK = 10,
  parameter int CNT_W = 9,
  parameter int AW    = 6
) ();
  localparam int IW = clog2(N_OUT);

  // A transfer happens on a rising edge where valid && ready; the producer holds
  // data stable while valid is high and unaccepted, and ready may not depend on valid.
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_vec;
  logic             w_rd_en;
  logic [AW-1:0]    w_rd_addr;
  logic [CHUNK-1:0] w_rd_data;
  logic             th_wr_en;
  logic [IW-1:0]    th_wr_idx;
  logic [CNT_W-1:0] th_wr_data;
  logic             th_wr_err;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_vec;
  state_t           dbg_state;

  modport slave (
    input  in_valid, in_vec, w_rd_data, th_wr_en, th_wr_idx, th_wr_data, abort, out_ready,
    output in_ready, w_rd_en, w_rd_addr, th_wr_err, out_valid, out_vec, dbg_state
  );

  modport master (
    output in_valid, in_vec, w_rd_data, th_wr_en, th_wr_idx, th_wr_data, abort, out_ready,
    input  in_ready, w_rd_en, w_rd_addr, th_wr_err, out_valid, out_vec, dbg_state
  );
endinterface

// File: rtl/bnn_xnor_popcnt.sv
// One shared XNOR-popcount lane: counts matching weight/input bits under a valid mask.
module bnn_xnor_popcnt import bnn_pkg::*; #(
  parameter int CHUNK = 10,
  parameter int CNT_W = 9
) (
  input  logic [CHUNK-1:0] w,
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] mask,
  output logic [CNT_W-1:0] cnt
);
  logic [POP_MAX_W-1:0] bits;

  always_comb begin
    bits = '0;
    bits[CHUNK-1:0] = ~(w ^ x) & mask;
    cnt = CNT_W'(popcount(bits));
  end
endmodule

// File: rtl/bnn_layer_seq.sv
// Time-multiplexed binarised dense layer: streams weight rows from a sync ROM through one lane.
module bnn_layer_seq import bnn_pkg::*; #(
  parameter int N_IN  = 50,
  parameter int N_OUT = 10,
  parameter int CHUNK = 10,
  parameter int CNT_W = 9,
  parameter int AW    = 6
) (
  input logic            clk,
  input logic            rst_n,
  bnn_layer_seq_if.slave bus
);
  localparam int NCH   = nchunk(N_IN, CHUNK);
  localparam int NW    = clog2(N_OUT);
  localparam int CW    = clog2(NCH);
  localparam int PAD_W = NCH * CHUNK;

  state_t           state;
  logic [N_IN-1:0]  in_q;
  logic [NW-1:0]    rd_n, d_n;
  logic [CW-1:0]    rd_c, d_c;
  logic             d_vld;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] th [N_OUT];
  logic [PAD_W-1:0] in_pad;
  logic [CHUNK-1:0] x_chunk, mask;
  logic [CNT_W-1:0] pop, sum;
  logic             last_rd;

  // d_n/d_c tag the ROM word arriving this cycle; bits past N_IN are masked out.
  always_comb begin
    in_pad = '0;
    in_pad[N_IN-1:0] = in_q;
    x_chunk = in_pad[int'(d_c)*CHUNK +: CHUNK];
    mask = '0;
    for (int j = 0; j < CHUNK; j++) mask[j] = (int'(d_c) * CHUNK + j) < N_IN;
    sum = pop;
    if (d_c != '0) sum = acc + pop;
    last_rd = (rd_n == NW'(N_OUT - 1)) && (rd_c == CW'(NCH - 1));
  end

  bnn_xnor_popcnt #(.CHUNK(CHUNK), .CNT_W(CNT_W)) u_lane (
    .w    (bus.w_rd_data),
    .x    (x_chunk),
    .mask (mask),
    .cnt  (pop)
  );

  assign bus.dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_q          <= '0;
      rd_n          <= '0;
      rd_c          <= '0;
      d_n           <= '0;
      d_c           <= '0;
      d_vld         <= 1'b0;
      acc           <= '0;
      for (int i = 0; i < N_OUT; i++) th[i] <= '0;
      bus.in_ready  <= 1'b1;
      bus.w_rd_en   <= 1'b0;
      bus.w_rd_addr <= '0;
      bus.th_wr_err <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_vec   <= '0;
    end else begin
      bus.th_wr_err <= bus.th_wr_en && ((state != IDLE) || (int'(bus.th_wr_idx) >= N_OUT));
      if (bus.th_wr_en && (state == IDLE) && (int'(bus.th_wr_idx) < N_OUT))
        th[bus.th_wr_idx] <= bus.th_wr_data;

      if (bus.abort) begin
        state         <= IDLE;
        d_vld         <= 1'b0;
        bus.in_ready  <= 1'b1;
        bus.w_rd_en   <= 1'b0;
        bus.out_valid <= 1'b0;
        bus.out_vec   <= '0;
      end else begin
        d_vld <= bus.w_rd_en;
        d_n   <= rd_n;
        d_c   <= rd_c;
        if (d_vld) begin
          acc <= sum;
          if (d_c == CW'(NCH - 1)) bus.out_vec[d_n] <= (sum > th[d_n]);
        end

        case (state)
          IDLE: begin
            if (bus.in_valid && bus.in_ready) begin
              in_q          <= bus.in_vec;
              rd_n          <= '0;
              rd_c          <= '0;
              bus.w_rd_addr <= '0;
              bus.w_rd_en   <= 1'b1;
              bus.in_ready  <= 1'b0;
              bus.out_vec   <= '0;
              state         <= RUN;
            end
          end
          RUN: begin
            if (last_rd) begin
              bus.w_rd_en <= 1'b0;
              state       <= DRAIN;
            end else begin
              bus.w_rd_addr <= bus.w_rd_addr + 1'b1;
              if (rd_c == CW'(NCH - 1)) begin
                rd_c <= '0;
                rd_n <= rd_n + 1'b1;
              end else begin
                rd_c <= rd_c + 1'b1;
              end
            end
          end
          DRAIN: begin
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
          DONE: begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              bus.in_ready  <= 1'b1;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed bench for bnn_layer_seq with a behavioural synchronous weight ROM.
module tb_bnn_layer_seq;
  import bnn_pkg::*;

  localparam int N_IN    = 50;
  localparam int N_OUT   = 10;
  localparam int CHUNK   = 10;
  localparam int CNT_W   = 9;
  localparam int AW      = 6;
  localparam int NCH     = 5;
  localparam int NR      = 50;
  localparam int LAT_EXP = 51;
  localparam int IW      = 4;
  localparam logic [N_IN-1:0] ALL1  = '1;
  localparam logic [N_IN-1:0] LOW25 = 50'h1FFFFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bnn_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .CHUNK(CHUNK), .CNT_W(CNT_W), .AW(AW)) bus ();

  bnn_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .CHUNK(CHUNK), .CNT_W(CNT_W), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [CHUNK-1:0] rom [2**AW];
  always @(posedge clk) if (bus.w_rd_en) bus.w_rd_data <= rom[bus.w_rd_addr];

  int n_checks = 0;
  int n_errors = 0;
  logic [N_OUT-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.in_vec     = '0;
    bus.th_wr_en   = 1'b0;
    bus.th_wr_idx  = '0;
    bus.th_wr_data = '0;
    bus.abort      = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic set_row(input int n, input logic [N_IN-1:0] row);
    for (int c = 0; c < NCH; c++) rom[n*NCH + c] = row[c*CHUNK +: CHUNK];
  endtask

  task automatic rom_even_odd();
    for (int n = 0; n < N_OUT; n++) set_row(n, (n % 2 == 0) ? ALL1 : '0);
  endtask

  task automatic rom_all_ones();
    for (int n = 0; n < N_OUT; n++) set_row(n, ALL1);
  endtask

  task automatic write_th(input int idx, input int val, output logic err);
    @(negedge clk);
    bus.th_wr_en   = 1'b1;
    bus.th_wr_idx  = IW'(idx);
    bus.th_wr_data = CNT_W'(val);
    @(negedge clk);
    bus.th_wr_en = 1'b0;
    err = bus.th_wr_err;
  endtask

  task automatic set_th_all(input string tag, input int val);
    logic e;
    int bad;
    bad = 0;
    for (int n = 0; n < N_OUT; n++) begin
      write_th(n, val, e);
      if (e !== 1'b0) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic start_vec(input logic [N_IN-1:0] v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // lat counts rising edges since the accept edge; checks the read address stream on the way.
  task automatic wait_out(input int lat0, output int lat, output int addr_bad);
    lat = lat0;
    addr_bad = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (lat < NR) begin
        if (bus.w_rd_en !== 1'b1 || int'(bus.w_rd_addr) != lat) addr_bad++;
      end else if (bus.w_rd_en !== 1'b0) begin
        addr_bad++;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_only(input string tag, input logic [N_IN-1:0] v, input logic [N_OUT-1:0] exp);
    int lat, bad;
    exp_q.push_back(exp);
    start_vec(v);
    wait_out(0, lat, bad);
    check({tag, "_lat"}, 32'(lat), 32'(LAT_EXP));
    check({tag, "_addr"}, 32'(bad), 32'd0);
    check({tag, "_vec"}, 32'(bus.out_vec), 32'(exp_q.pop_front()));
  endtask

  task automatic run_and_check(input string tag, input logic [N_IN-1:0] v, input logic [N_OUT-1:0] exp);
    run_only(tag, v, exp);
    accept_out();
  endtask

  initial begin
    logic e;
    int lat, bad, stable_bad;
    int th_tab [N_OUT];

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_vec",   32'(bus.out_vec),   32'd0);
    check("rst_w_rd_en",   32'(bus.w_rd_en),   32'd0);
    check("rst_w_rd_addr", 32'(bus.w_rd_addr), 32'd0);
    check("rst_th_wr_err", 32'(bus.th_wr_err), 32'd0);
    check("rst_state",     32'(bus.dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Even neurons all-ones rows, odd all-zero, all thresholds 25.
    rom_even_odd();
    set_th_all("setup_th_err", 25);
    run_only("setup", ALL1, 10'b0101010101);

    // Hold the result under backpressure and pulse a vector that must be ignored.
    stable_bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i == 5);
      bus.in_vec   = '0;
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_vec !== 10'b0101010101 || bus.in_ready !== 1'b0 ||
          bus.w_rd_en !== 1'b0 || bus.dbg_state !== DONE) stable_bad++;
    end
    bus.in_valid = 1'b0;
    check("bp_stable", 32'(stable_bad), 32'd0);
    accept_out();
    check("bp_in_ready",  32'(bus.in_ready),  32'd1);
    check("bp_out_valid", 32'(bus.out_valid), 32'd0);
    run_and_check("bp_next", ALL1, 10'b0101010101);

    // Every neuron sees popcount 25: th 25 -> 0, th 24 -> 1, th 0 -> 1.
    rom_all_ones();
    write_th(1, 24, e);
    write_th(2, 0, e);
    run_and_check("pop25", LOW25, 10'b0000000110);

    // Full match popcount 50: th 49 -> 1, th 50 -> 0.
    write_th(3, 49, e);
    write_th(4, 50, e);
    run_and_check("pop50", ALL1, 10'b1111101111);

    // Row n has its low 5n bits set; popcounts 25,30,35,40,45,50,45,40,35,30.
    for (int n = 0; n < N_OUT; n++) begin
      logic [63:0] t;
      t = (64'd1 << (5 * n)) - 64'd1;
      set_row(n, t[N_IN-1:0]);
    end
    th_tab = '{24, 30, 34, 39, 44, 49, 45, 39, 35, 29};
    bad = 0;
    for (int n = 0; n < N_OUT; n++) begin
      write_th(n, th_tab[n], e);
      if (e !== 1'b0) bad++;
    end
    check("tab_th_err", 32'(bad), 32'd0);
    start_vec(LOW25);
    write_th(3, 40, e);
    check("run_wr_err", 32'(e), 32'd1);
    wait_out(2, lat, bad);
    check("run_wr_lat",  32'(lat), 32'(LAT_EXP));
    check("run_wr_addr", 32'(bad), 32'd0);
    check("run_wr_vec",  32'(bus.out_vec), 32'(10'b1010111101));
    accept_out();

    write_th(12, 7, e);
    check("idx12_err", 32'(e), 32'd1);
    @(negedge clk);
    check("idx12_pulse", 32'(bus.th_wr_err), 32'd0);
    write_th(3, 40, e);
    check("idle_wr_err", 32'(e), 32'd0);
    run_and_check("idle_wr", LOW25, 10'b1010110101);

    // Abort during the 17th read cycle, then a clean run.
    rom_even_odd();
    set_th_all("abort_th_err", 25);
    start_vec(ALL1);
    repeat (16) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_state",     32'(bus.dbg_state), 32'(IDLE));
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_w_rd_en",   32'(bus.w_rd_en),   32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    run_and_check("post_abort", ALL1, 10'b0101010101);

    // Asynchronous reset in the middle of a run clears outputs and thresholds.
    rom_all_ones();
    start_vec(ALL1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_w_rd_en",   32'(bus.w_rd_en),   32'd0);
    check("mrst_w_rd_addr", 32'(bus.w_rd_addr), 32'd0);
    check("mrst_out_vec",   32'(bus.out_vec),   32'd0);
    check("mrst_state",     32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("th_zero", LOW25, 10'b1111111111);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
